// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - registered 8085-style ALU with iterative unsigned MUL/DIV
// One op in flight; flag register updates on the edge that enters DONE.
module alu_seq_core #(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             flags_load,
  input  logic [7:0]       flags_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0] FLAG_MASK = 8'hD5;

  localparam logic [4:0] OP_AND = 5'h00;
  localparam logic [4:0] OP_CMA = 5'h01;
  localparam logic [4:0] OP_OR  = 5'h02;
  localparam logic [4:0] OP_XOR = 5'h03;
  localparam logic [4:0] OP_ADD = 5'h04;
  localparam logic [4:0] OP_ADC = 5'h05;
  localparam logic [4:0] OP_SUB = 5'h06;
  localparam logic [4:0] OP_SBB = 5'h07;
  localparam logic [4:0] OP_INR = 5'h08;
  localparam logic [4:0] OP_DCR = 5'h09;
  localparam logic [4:0] OP_ROL = 5'h0A;
  localparam logic [4:0] OP_ROR = 5'h0B;
  localparam logic [4:0] OP_RLC = 5'h0C;
  localparam logic [4:0] OP_RRC = 5'h0D;
  localparam logic [4:0] OP_CMP = 5'h0E;
  localparam logic [4:0] OP_MUL = 5'h0F;
  localparam logic [4:0] OP_DIV = 5'h10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  function automatic logic [7:0] pack_flags(input logic s, input logic z, input logic ac,
                                            input logic p, input logic cy);
    return {s, z, 1'b0, ac, 1'b0, p, 1'b0, cy};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [7:0]       flags_q, flags_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;

  logic [7:0]       base_flags;
  logic             cin;
  logic [WIDTH-1:0] rhs;
  logic             use_c;
  logic             do_sub;
  logic [WIDTH:0]   c_ext;
  logic [WIDTH:0]   arith;
  logic             arith_ac;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] zsp_src;
  logic             alu_cy;
  logic             alu_ac;
  logic             alu_rot;
  logic             alu_undef;
  logic [7:0]       alu_flags;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_geq;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic             is_md;
  logic             div_zero;

  // A load in the accept cycle supplies the CY (and untouched flags) to that op.
  always_comb begin
    base_flags = flags_load ? (flags_in & FLAG_MASK) : flags_q;
    cin        = base_flags[0];
  end

  always_comb begin
    rhs    = operand;
    use_c  = 1'b0;
    do_sub = 1'b0;
    case (opcode)
      OP_ADC: use_c = 1'b1;
      OP_SUB: do_sub = 1'b1;
      OP_SBB: begin
        do_sub = 1'b1;
        use_c  = 1'b1;
      end
      OP_INR: rhs = WIDTH'(1);
      OP_DCR: begin
        rhs    = WIDTH'(1);
        do_sub = 1'b1;
      end
      OP_CMP: do_sub = 1'b1;
      default: ;
    endcase
    c_ext = {{WIDTH{1'b0}}, use_c & cin};
    if (do_sub) begin
      arith = {1'b0, acc} - {1'b0, rhs} - c_ext;
    end else begin
      arith = {1'b0, acc} + {1'b0, rhs} + c_ext;
    end
    // Carry/borrow into bit 4 recovered from the sum bit, no separate nibble adder.
    arith_ac = acc[4] ^ rhs[4] ^ arith[4];
  end

  always_comb begin
    alu_res   = '0;
    alu_cy    = 1'b0;
    alu_ac    = 1'b0;
    alu_rot   = 1'b0;
    alu_undef = 1'b0;
    case (opcode)
      OP_AND: alu_res = acc & operand;
      OP_CMA: alu_res = ~acc;
      OP_OR:  alu_res = acc | operand;
      OP_XOR: alu_res = acc ^ operand;
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INR, OP_DCR: begin
        alu_res = arith[WIDTH-1:0];
        alu_cy  = arith[WIDTH];
        alu_ac  = arith_ac;
      end
      OP_ROL: begin
        alu_res = {acc[WIDTH-2:0], acc[WIDTH-1]};
        alu_cy  = acc[WIDTH-1];
        alu_rot = 1'b1;
      end
      OP_ROR: begin
        alu_res = {acc[0], acc[WIDTH-1:1]};
        alu_cy  = acc[0];
        alu_rot = 1'b1;
      end
      OP_RLC: begin
        alu_res = {acc[WIDTH-2:0], cin};
        alu_cy  = acc[WIDTH-1];
        alu_rot = 1'b1;
      end
      OP_RRC: begin
        alu_res = {cin, acc[WIDTH-1:1]};
        alu_cy  = acc[0];
        alu_rot = 1'b1;
      end
      OP_CMP: begin
        alu_res = acc;
        alu_cy  = arith[WIDTH];
        alu_ac  = arith_ac;
      end
      default: alu_undef = 1'b1;
    endcase
    zsp_src = (opcode == OP_CMP) ? arith[WIDTH-1:0] : alu_res;
    if (alu_rot) begin
      alu_flags = pack_flags(base_flags[7], base_flags[6], 1'b0, base_flags[2], alu_cy);
    end else begin
      alu_flags = pack_flags(zsp_src[WIDTH-1], zsp_src == '0, alu_ac, ~^zsp_src, alu_cy);
    end
  end

  // hi_q/lo_q hold partial product/multiplier for MUL and remainder/quotient for DIV.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_geq   = div_shift >= {1'b0, opd_q};
    if (is_div_q) begin
      it_hi = div_geq ? (div_shift[WIDTH-1:0] - opd_q) : div_shift[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_geq};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opd_d       = opd_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_md       = MULDIV_EN && ((opcode == OP_MUL) || (opcode == OP_DIV));
    div_zero    = (opcode == OP_DIV) && (operand == '0);
    case (state_q)
      S_IDLE: begin
        if (flags_load) begin
          flags_d = flags_in & FLAG_MASK;
        end
        if (in_valid) begin
          if (is_md && !div_zero) begin
            state_d  = S_EXEC;
            hi_d     = '0;
            lo_d     = acc;
            opd_d    = operand;
            cnt_d    = '0;
            is_div_d = (opcode == OP_DIV);
          end else if (is_md) begin
            state_d     = S_DONE;
            result_d    = '1;
            result_hi_d = acc;
            flags_d     = pack_flags(1'b1, 1'b0, 1'b0, ~^{WIDTH{1'b1}}, 1'b1);
          end else if (alu_undef) begin
            state_d     = S_DONE;
            result_d    = '0;
            result_hi_d = '0;
            flags_d     = base_flags;
          end else begin
            state_d     = S_DONE;
            result_d    = alu_res;
            result_hi_d = '0;
            flags_d     = alu_flags;
          end
        end
      end
      S_EXEC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          result_d    = it_lo;
          result_hi_d = it_hi;
          if (is_div_q) begin
            flags_d = pack_flags(it_lo[WIDTH-1], it_lo == '0, 1'b0, ~^it_lo, 1'b0);
          end else begin
            flags_d = pack_flags(it_lo[WIDTH-1], (it_lo == '0) && (it_hi == '0), 1'b0,
                                 ~^it_lo, it_hi != '0);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= 8'h00;
      hi_q        <= '0;
      lo_q        <= '0;
      opd_q       <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opd_q       <= opd_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - randomized bench for alu_seq_core at WIDTH=8 and WIDTH=16
// Both widths share the input buses (8-bit instance sees the low byte) and are checked against one model.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [15:0] acc_bus;
  logic [15:0] operand_bus;
  logic        flags_load;
  logic [7:0]  flags_in;
  logic        out_ready;

  logic        in_ready8, out_valid8, in_ready16, out_valid16;
  logic [7:0]  result8, result_hi8, flags8, flags16;
  logic [15:0] result16, result_hi16;

  logic [15:0] res_w [2];
  logic [15:0] hi_w  [2];
  logic [7:0]  fl_w  [2];
  logic        ov_w  [2];
  logic        rdy_w [2];

  int          n_chk = 0;
  int          n_err = 0;
  int          wid [2] = '{8, 16};
  logic [7:0]  mflags [2];

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(8), .MULDIV_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .opcode(opcode),
    .acc(acc_bus[7:0]), .operand(operand_bus[7:0]), .flags_load(flags_load), .flags_in(flags_in),
    .out_valid(out_valid8), .out_ready(out_ready), .result(result8), .result_hi(result_hi8),
    .flags(flags8)
  );

  alu_seq_core #(.WIDTH(16), .MULDIV_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .opcode(opcode),
    .acc(acc_bus), .operand(operand_bus), .flags_load(flags_load), .flags_in(flags_in),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16), .result_hi(result_hi16),
    .flags(flags16)
  );

  assign res_w[0] = {8'h00, result8};
  assign res_w[1] = result16;
  assign hi_w[0]  = {8'h00, result_hi8};
  assign hi_w[1]  = result_hi16;
  assign fl_w[0]  = flags8;
  assign fl_w[1]  = flags16;
  assign ov_w[0]  = out_valid8;
  assign ov_w[1]  = out_valid16;
  assign rdy_w[0] = in_ready8;
  assign rdy_w[1] = in_ready16;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic void model(input int w, input logic [4:0] op, input logic [15:0] a_in,
                                input logic [15:0] b_in, input logic [7:0] fl,
                                output longint r, output longint h, output logic [7:0] nf,
                                output int lat);
    longint m, a, b, c, t, zs;
    logic cy, ac, rot, undef, s, z, p;
    m = (longint'(1) << w) - 1;
    a = longint'(a_in) & m;
    b = longint'(b_in) & m;
    c = longint'(fl[0]);
    r = 0; h = 0; lat = 1; t = 0; zs = 0;
    cy = 1'b0; ac = 1'b0; rot = 1'b0; undef = 1'b0;
    case (op)
      5'h00: r = a & b;
      5'h01: r = ~a & m;
      5'h02: r = a | b;
      5'h03: r = a ^ b;
      5'h04: begin t = a + b; r = t & m; cy = (t > m); ac = ((a & 15) + (b & 15)) > 15; end
      5'h05: begin t = a + b + c; r = t & m; cy = (t > m); ac = ((a & 15) + (b & 15) + c) > 15; end
      5'h06: begin r = (a - b) & m; cy = (a < b); ac = ((a & 15) < (b & 15)); end
      5'h07: begin r = (a - b - c) & m; cy = (a < b + c); ac = ((a & 15) < (b & 15) + c); end
      5'h08: begin r = (a + 1) & m; cy = (a == m); ac = ((a & 15) == 15); end
      5'h09: begin r = (a - 1) & m; cy = (a == 0); ac = ((a & 15) == 0); end
      5'h0A: begin r = ((a << 1) | (a >> (w - 1))) & m; cy = ((a >> (w - 1)) & 1) != 0; rot = 1'b1; end
      5'h0B: begin r = (a >> 1) | ((a & 1) << (w - 1)); cy = (a & 1) != 0; rot = 1'b1; end
      5'h0C: begin r = ((a << 1) & m) | c; cy = ((a >> (w - 1)) & 1) != 0; rot = 1'b1; end
      5'h0D: begin r = (a >> 1) | (c << (w - 1)); cy = (a & 1) != 0; rot = 1'b1; end
      5'h0E: begin r = a; zs = (a - b) & m; cy = (a < b); ac = ((a & 15) < (b & 15)); end
      5'h0F: begin t = a * b; r = t & m; h = t >> w; cy = (h != 0); lat = w + 1; end
      5'h10: begin
        if (b == 0) begin
          r = m; h = a; cy = 1'b1;
        end else begin
          r = a / b; h = a % b; lat = w + 1;
        end
      end
      default: undef = 1'b1;
    endcase
    if (op != 5'h0E) zs = r;
    s = zs[w-1];
    z = (op == 5'h0F) ? (t == 0) : (zs == 0);
    p = ($countones(zs) % 2) == 0;
    if (undef) nf = fl;
    else if (rot) nf = {fl[7], fl[6], 3'b000, fl[2], 1'b0, cy};
    else nf = {s, z, 1'b0, ac, 1'b0, p, 1'b0, cy};
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit ld, input logic [7:0] fi, input bit hold);
    longint     er [2];
    longint     eh [2];
    logic [7:0] ef [2];
    int         el [2];
    bit         seen [2];
    for (int i = 0; i < 2; i++) begin
      model(wid[i], op, a, b, ld ? (fi & 8'hD5) : mflags[i], er[i], eh[i], ef[i], el[i]);
      seen[i] = 1'b0;
    end
    in_valid = 1'b1; opcode = op; acc_bus = a; operand_bus = b;
    flags_load = ld; flags_in = fi; out_ready = !hold;
    @(posedge clk); #1;
    in_valid = 1'b0; flags_load = 1'b0;
    acc_bus = 16'($urandom); operand_bus = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!seen[i]) begin
          if (ov_w[i]) begin
            seen[i] = 1'b1;
            check_eq($sformatf("lat_op%0h_w%0d", op, wid[i]), k, el[i]);
            check_eq($sformatf("res_op%0h_w%0d", op, wid[i]), res_w[i], er[i]);
            check_eq($sformatf("hi_op%0h_w%0d", op, wid[i]), hi_w[i], eh[i]);
            check_eq($sformatf("flags_op%0h_w%0d", op, wid[i]), fl_w[i], ef[i]);
            mflags[i] = ef[i];
          end else begin
            check_eq($sformatf("busy_ready_w%0d", wid[i]), rdy_w[i], 0);
          end
        end
      end
      if (seen[0] && seen[1]) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      if (!seen[i]) check_eq($sformatf("timeout_op%0h_w%0d", op, wid[i]), 0, 1);
    end
    if (hold) begin
      for (int j = 0; j < 5; j++) begin
        in_valid = 1'b1; opcode = 5'($urandom); flags_load = 1'b1; flags_in = 8'($urandom);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
          check_eq($sformatf("hold_valid_w%0d", wid[i]), ov_w[i], 1);
          check_eq($sformatf("hold_ready_w%0d", wid[i]), rdy_w[i], 0);
          check_eq($sformatf("hold_res_w%0d", wid[i]), res_w[i], er[i]);
          check_eq($sformatf("hold_hi_w%0d", wid[i]), hi_w[i], eh[i]);
          check_eq($sformatf("hold_flags_w%0d", wid[i]), fl_w[i], ef[i]);
        end
      end
      in_valid = 1'b0; flags_load = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("back_idle_w%0d", wid[i]), rdy_w[i], 1);
      check_eq($sformatf("idle_flags_w%0d", wid[i]), fl_w[i], mflags[i]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_ready_w%0d", tag, wid[i]), rdy_w[i], 1);
      check_eq($sformatf("%s_valid_w%0d", tag, wid[i]), ov_w[i], 0);
      check_eq($sformatf("%s_res_w%0d", tag, wid[i]), res_w[i], 0);
      check_eq($sformatf("%s_hi_w%0d", tag, wid[i]), hi_w[i], 0);
      check_eq($sformatf("%s_flags_w%0d", tag, wid[i]), fl_w[i], 0);
      mflags[i] = 8'h00;
    end
  endtask

  initial begin
    logic [4:0]  rop;
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; acc_bus = '0; operand_bus = '0;
    flags_load = 1'b0; flags_in = '0; out_ready = 1'b1;
    mflags[0] = 8'h00; mflags[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    run_op(5'h04, 16'hFFFF, 16'h0001, 1'b0, 8'h00, 1'b0);
    check_eq("t1_flags_w8", flags8, 8'h55);
    check_eq("t1_res_w8", result8, 8'h00);
    run_op(5'h05, 16'h0005, 16'h0003, 1'b1, 8'h01, 1'b0);
    check_eq("t2_res_w8", result8, 8'h09);
    check_eq("t2_cy_w8", flags8[0], 1'b0);
    run_op(5'h07, 16'h0000, 16'h0000, 1'b1, 8'h01, 1'b0);
    check_eq("t3_res_w8", result8, 8'hFF);
    check_eq("t3_flags_w8", flags8, 8'h95);
    run_op(5'h0F, 16'hFFFF, 16'hFFFF, 1'b0, 8'h00, 1'b0);
    check_eq("t4_res_w8", result8, 8'h01);
    check_eq("t4_hi_w8", result_hi8, 8'hFE);
    check_eq("t4_cy_w8", flags8[0], 1'b1);
    run_op(5'h10, 16'h0064, 16'h0007, 1'b0, 8'h00, 1'b0);
    check_eq("t5_res_w8", result8, 8'h0E);
    check_eq("t5_hi_w8", result_hi8, 8'h02);
    run_op(5'h10, 16'h0010, 16'h0000, 1'b0, 8'h00, 1'b0);
    check_eq("t5z_res_w8", result8, 8'hFF);
    check_eq("t5z_hi_w8", result_hi8, 8'h10);
    run_op(5'h0F, 16'h1234, 16'h00AB, 1'b0, 8'h00, 1'b1);
    run_op(5'h03, 16'h5A5A, 16'h0FF0, 1'b0, 8'h00, 1'b1);

    flags_load = 1'b1; flags_in = 8'hFF;
    @(posedge clk); #1;
    flags_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("fload_w%0d", wid[i]), fl_w[i], 8'hD5);
      mflags[i] = 8'hD5;
    end
    run_op(5'h0C, 16'h4321, 16'h0000, 1'b0, 8'h00, 1'b0);
    run_op(5'h15, 16'h1111, 16'h2222, 1'b0, 8'h00, 1'b0);

    in_valid = 1'b1; opcode = 5'h0F; acc_bus = 16'hBEEF; operand_bus = 16'h1357;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (20) @(posedge clk);
    #1;
    check_eq("midrst_drop_w8", out_valid8, 0);
    check_eq("midrst_drop_w16", out_valid16, 0);

    for (int n = 0; n < 120; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(15, 16)) : 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      run_op(rop, ra, rb, ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
